// File: rtl/dsi_hs_sequencer.sv
// HS burst sequencer for a DSI link: raises the clock lane, then the data lanes,
// streams packet beats, and tears the lanes down in reverse order.
module dsi_hs_sequencer #(
    parameter int LANES      = 2,
    parameter int T_CLK_PRE  = 8,
    parameter int T_CLK_POST = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 byte_clk,
    input  logic                 byte_rst,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 cont_clk,
    output logic                 clk_hs_req,
    input  logic                 clk_hs_rdy,
    input  logic                 clk_idle,
    output logic                 dl_hs_req,
    input  logic [LANES-1:0]     dl_hs_rdy,
    input  logic [LANES-1:0]     dl_idle,
    output logic [8*LANES-1:0]   dl_data,
    output logic                 dl_enable,
    output logic                 busy,
    output logic                 underrun,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        IDLE, CLK_START, CLK_PRE, DL_START, SEND, DL_STOP, CLK_POST, CLK_STOP, CLK_ON
    } state_t;

    state_t      state, next_state;
    logic [15:0] to_cnt, to_cnt_d;
    logic [7:0]  tm_cnt, tm_cnt_d;
    logic        wait_state, wait_done, timed_out;
    state_t      wait_next;
    logic        clk_hs_req_d, dl_hs_req_d, busy_d, underrun_d, timeout_err_d;

    // Registered outputs are computed from next_state so they line up with the state they belong to.
    always_ff @(posedge byte_clk or posedge byte_rst) begin
        if (byte_rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            tm_cnt      <= '0;
            clk_hs_req  <= 1'b0;
            dl_hs_req   <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state       <= next_state;
            to_cnt      <= to_cnt_d;
            tm_cnt      <= tm_cnt_d;
            clk_hs_req  <= clk_hs_req_d;
            dl_hs_req   <= dl_hs_req_d;
            busy        <= busy_d;
            underrun    <= underrun_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        next_state = state;
        wait_state = 1'b0;
        wait_done  = 1'b0;
        wait_next  = state;
        case (state)
            IDLE:      if (in_valid) next_state = CLK_START;
            CLK_START: begin
                wait_state = 1'b1;
                wait_done  = clk_hs_rdy;
                wait_next  = CLK_PRE;
            end
            CLK_PRE:   if (tm_cnt == 8'(T_CLK_PRE - 1)) next_state = DL_START;
            DL_START:  begin
                wait_state = 1'b1;
                wait_done  = &dl_hs_rdy;
                wait_next  = SEND;
            end
            SEND:      if (in_valid && in_last) next_state = DL_STOP;
            DL_STOP:   begin
                wait_state = 1'b1;
                wait_done  = &dl_idle;
                wait_next  = cont_clk ? CLK_ON : CLK_POST;
            end
            CLK_POST:  if (tm_cnt == 8'(T_CLK_POST - 1)) next_state = CLK_STOP;
            CLK_STOP:  begin
                wait_state = 1'b1;
                wait_done  = clk_idle;
                wait_next  = IDLE;
            end
            CLK_ON:    begin
                if (in_valid)      next_state = DL_START;
                else if (!cont_clk) next_state = CLK_POST;
            end
            default:   next_state = IDLE;
        endcase

        // The error pulse has already gone out one cycle earlier, so the abort wins here.
        timed_out = wait_state && (to_cnt == 16'(TIMEOUT));
        if (timed_out)                    next_state = IDLE;
        else if (wait_state && wait_done) next_state = wait_next;

        if (next_state != state)                  to_cnt_d = '0;
        else if (wait_state)                      to_cnt_d = to_cnt + 16'd1;
        else                                      to_cnt_d = '0;

        if (next_state != state)                  tm_cnt_d = '0;
        else if (state inside {CLK_PRE, CLK_POST}) tm_cnt_d = tm_cnt + 8'd1;
        else                                      tm_cnt_d = '0;
    end

    always_comb begin
        clk_hs_req_d  = next_state inside {CLK_START, CLK_PRE, DL_START, SEND, DL_STOP, CLK_POST, CLK_ON};
        dl_hs_req_d   = next_state inside {DL_START, SEND};
        busy_d        = next_state != IDLE;
        timeout_err_d = wait_state && (next_state == state) && (to_cnt + 16'd1 == 16'(TIMEOUT));

        underrun_d = underrun;
        if (next_state == DL_START && state != DL_START) underrun_d = 1'b0;
        else if (state == SEND && !in_valid)             underrun_d = 1'b1;

        in_ready  = state == SEND;
        dl_enable = in_ready && in_valid;
        dl_data   = in_ready ? in_data : '0;
    end

endmodule

// File: tb/tb_dsi_hs_sequencer.sv
// Directed bench for dsi_hs_sequencer: PHY lane responders, beat scoreboard,
// lane timing, partial ready, underrun, continuous clock, timeout and reset.
module tb_dsi_hs_sequencer;

    localparam int LANES  = 2;
    localparam int T_PRE  = 8;
    localparam int T_POST = 8;
    localparam int W      = 8 * LANES;

    logic             byte_clk = 1'b0;
    logic             byte_rst = 1'b1;
    logic [W-1:0]     in_data;
    logic             in_valid, in_last, in_ready, cont_clk;
    logic             clk_hs_req, clk_hs_rdy, clk_idle;
    logic             dl_hs_req;
    logic [LANES-1:0] dl_hs_rdy, dl_idle;
    logic [W-1:0]     dl_data;
    logic             dl_enable, busy, underrun, timeout_err;

    logic             t_in_valid, t_in_ready, t_clk_hs_req, t_dl_hs_req;
    logic [W-1:0]     t_dl_data;
    logic             t_dl_enable, t_busy, t_underrun, t_timeout_err;

    logic [LANES-1:0] rdy_mask = '1;
    logic             dl_rdy_model = 1'b0;
    assign dl_hs_rdy = dl_rdy_model ? rdy_mask : '0;

    int passes = 0, total = 0;
    int cyc = 0;
    int enable_cnt = 0, clk_fall_count = 0;
    int clk_rdy_cyc = 0, dl_idle_cyc = 0, dl_req_rise_cyc = 0, clk_req_fall_cyc = 0;
    int clk_on = 0, clk_off = 3, dl_on = 0, dl_off = 3;
    logic prev_dl_req = 1'b0, prev_clk_req = 1'b0;
    logic [W-1:0] exp_q[$];

    always #5 byte_clk = ~byte_clk;

    dsi_hs_sequencer #(.LANES(LANES), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST), .TIMEOUT(1023)) dut (
        .byte_clk(byte_clk), .byte_rst(byte_rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .cont_clk(cont_clk),
        .clk_hs_req(clk_hs_req), .clk_hs_rdy(clk_hs_rdy), .clk_idle(clk_idle),
        .dl_hs_req(dl_hs_req), .dl_hs_rdy(dl_hs_rdy), .dl_idle(dl_idle),
        .dl_data(dl_data), .dl_enable(dl_enable),
        .busy(busy), .underrun(underrun), .timeout_err(timeout_err)
    );

    // Second instance with a stuck clock lane for the timeout path.
    dsi_hs_sequencer #(.LANES(LANES), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST), .TIMEOUT(16)) dut_to (
        .byte_clk(byte_clk), .byte_rst(byte_rst),
        .in_data('0), .in_valid(t_in_valid), .in_last(1'b0), .in_ready(t_in_ready),
        .cont_clk(1'b0),
        .clk_hs_req(t_clk_hs_req), .clk_hs_rdy(1'b0), .clk_idle(1'b1),
        .dl_hs_req(t_dl_hs_req), .dl_hs_rdy('0), .dl_idle('1),
        .dl_data(t_dl_data), .dl_enable(t_dl_enable),
        .busy(t_busy), .underrun(t_underrun), .timeout_err(t_timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] beat_val(input logic [7:0] start, input int i);
        logic [W-1:0] b;
        for (int k = 0; k < LANES; k++) b[8*k +: 8] = start + 8'(LANES * i + k);
        return b;
    endfunction

    initial forever begin
        @(posedge byte_clk);
        cyc++;
    end

    // PHY responders: ready two cycles after a request, idle two cycles after release.
    initial begin
        clk_hs_rdy = 1'b0;
        clk_idle   = 1'b1;
        dl_idle    = '1;
        forever begin
            @(posedge byte_clk);
            #1;
            if (clk_hs_req) begin
                clk_off  = 0;
                clk_idle = 1'b0;
                clk_on++;
                if (clk_on >= 3 && !clk_hs_rdy) begin
                    clk_hs_rdy  = 1'b1;
                    clk_rdy_cyc = cyc;
                end
            end else begin
                clk_on     = 0;
                clk_hs_rdy = 1'b0;
                clk_off++;
                if (clk_off >= 3) clk_idle = 1'b1;
            end
            if (dl_hs_req) begin
                dl_off  = 0;
                dl_idle = '0;
                dl_on++;
                if (dl_on >= 3) dl_rdy_model = 1'b1;
            end else begin
                dl_on        = 0;
                dl_rdy_model = 1'b0;
                dl_off++;
                if (dl_off >= 3 && dl_idle != '1) begin
                    dl_idle     = '1;
                    dl_idle_cyc = cyc;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on every transferred beat, plus request edge times.
    initial forever begin
        @(negedge byte_clk);
        if (dl_enable) begin
            enable_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_beat", 32'(dl_data), 32'(exp_q.pop_front()));
        end
        if (dl_hs_req && !prev_dl_req) dl_req_rise_cyc = cyc;
        if (!clk_hs_req && prev_clk_req) begin
            clk_req_fall_cyc = cyc;
            clk_fall_count++;
        end
        prev_dl_req  = dl_hs_req;
        prev_clk_req = clk_hs_req;
    end

    task automatic put_beat(input logic [W-1:0] beat, input logic last, output int drive_cyc);
        int n;
        @(posedge byte_clk);
        #1;
        drive_cyc = cyc;
        in_data   = beat;
        in_valid  = 1'b1;
        in_last   = last;
        exp_q.push_back(beat);
        n = 0;
        do begin
            @(negedge byte_clk);
            n++;
        end while (!in_ready && n < 500);
        check("accept_wait", 32'(in_ready), 1);
    endtask

    task automatic drop_valid();
        @(posedge byte_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge byte_clk);
            n++;
        end while (busy && n < 500);
        check("idle_wait", 32'(busy), 0);
    endtask

    initial begin
        int base, dc, v, n;
        logic ok;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; cont_clk = 1'b0; t_in_valid = 1'b0;

        repeat (2) @(negedge byte_clk);
        check("rst_clk_hs_req", 32'(clk_hs_req), 0);
        check("rst_dl_hs_req", 32'(dl_hs_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_dl_enable", 32'(dl_enable), 0);
        check("rst_dl_data", 32'(dl_data), 0);
        @(posedge byte_clk);
        #1 byte_rst = 1'b0;

        // Single 3-beat burst with lane timing.
        base = enable_cnt;
        for (int i = 0; i < 3; i++) put_beat(beat_val(8'h01, i), i == 2, dc);
        drop_valid();
        wait_idle();
        check("t1_enable_cycles", 32'(enable_cnt - base), 3);
        check("t1_dl_req_after_clk_rdy", 32'(dl_req_rise_cyc - clk_rdy_cyc), T_PRE + 1);
        check("t1_clk_req_fall_after_dl_idle", 32'(clk_req_fall_cyc - dl_idle_cyc), T_POST + 1);
        check("t1_underrun", 32'(underrun), 0);

        // One-cycle valid gap mid-burst.
        base = enable_cnt;
        for (int i = 0; i < 4; i++) begin
            put_beat(beat_val(8'h10, i), i == 3, dc);
            if (i == 1) drop_valid();
        end
        drop_valid();
        wait_idle();
        check("t3_enable_cycles", 32'(enable_cnt - base), 4);
        check("t3_underrun_sticky", 32'(underrun), 1);

        // Partial data-lane ready holds the burst in DL_START.
        rdy_mask = 2'b01;
        @(posedge byte_clk);
        #1;
        in_data = beat_val(8'h20, 0); in_valid = 1'b1; in_last = 1'b0;
        exp_q.push_back(beat_val(8'h20, 0));
        n = 0;
        do begin @(negedge byte_clk); n++; end while (!clk_hs_req && n < 100);
        check("t2_underrun_before_dl_start", 32'(underrun), 1);
        n = 0;
        do begin @(negedge byte_clk); n++; end while (!dl_hs_req && n < 200);
        check("t2_dl_req_seen", 32'(dl_hs_req), 1);
        check("t2_underrun_cleared", 32'(underrun), 0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge byte_clk);
            if (in_ready !== 1'b0 || dl_enable !== 1'b0 || dl_data !== '0) ok = 1'b0;
        end
        check("t2_blocked_on_partial_rdy", 32'(ok), 1);
        @(posedge byte_clk);
        #1 rdy_mask = '1;
        @(negedge byte_clk);
        check("t2_ready_same_cycle", 32'(in_ready), 0);
        @(negedge byte_clk);
        check("t2_ready_next_cycle", 32'(in_ready), 1);
        put_beat(beat_val(8'h20, 1), 1'b0, dc);
        put_beat(beat_val(8'h20, 2), 1'b1, dc);
        drop_valid();
        wait_idle();

        // Continuous clock: two bursts, clock lane stays up.
        cont_clk = 1'b1;
        clk_fall_count = 0;
        for (int i = 0; i < 2; i++) put_beat(beat_val(8'h40, i), i == 1, dc);
        drop_valid();
        n = 0;
        do begin @(negedge byte_clk); n++; end while (dl_idle != '1 && n < 100);
        repeat (5) @(posedge byte_clk);
        put_beat(beat_val(8'h60, 0), 1'b0, v);
        check("t4_direct_dl_start", 32'(dl_req_rise_cyc - v), 1);
        put_beat(beat_val(8'h60, 1), 1'b1, dc);
        drop_valid();
        n = 0;
        do begin @(negedge byte_clk); n++; end while (dl_idle != '1 && n < 100);
        repeat (4) @(negedge byte_clk);
        check("t4_busy_in_clk_on", 32'(busy), 1);
        check("t4_clk_never_fell", 32'(clk_fall_count), 0);
        cont_clk = 1'b0;
        wait_idle();
        check("t4_clk_fell_once", 32'(clk_fall_count), 1);

        // Stuck clock lane on the TIMEOUT=16 instance.
        @(posedge byte_clk);
        #1 t_in_valid = 1'b1;
        @(negedge byte_clk);
        check("t5_req_before", 32'(t_clk_hs_req), 0);
        @(posedge byte_clk);
        #1 t_in_valid = 1'b0;
        @(negedge byte_clk);
        check("t5_req_rise", 32'(t_clk_hs_req), 1);
        ok = 1'b1;
        repeat (15) begin
            @(negedge byte_clk);
            if (t_timeout_err !== 1'b0) ok = 1'b0;
        end
        check("t5_no_early_timeout", 32'(ok), 1);
        @(negedge byte_clk);
        check("t5_timeout_pulse", 32'(t_timeout_err), 1);
        check("t5_req_held_at_pulse", 32'(t_clk_hs_req), 1);
        check("t5_quiet_lanes", 32'({t_dl_hs_req, t_in_ready, t_dl_enable, t_underrun}), 0);
        check("t5_dl_data", 32'(t_dl_data), 0);
        @(negedge byte_clk);
        check("t5_timeout_single", 32'(t_timeout_err), 0);
        check("t5_req_dropped", 32'(t_clk_hs_req), 0);
        check("t5_busy", 32'(t_busy), 0);
        @(posedge byte_clk);
        #1 t_in_valid = 1'b1;
        @(negedge byte_clk);
        @(negedge byte_clk);
        check("t5_restart", 32'(t_clk_hs_req), 1);
        t_in_valid = 1'b0;

        // Reset in the middle of SEND, then a clean burst.
        put_beat(beat_val(8'h70, 0), 1'b0, dc);
        #2 byte_rst = 1'b1;
        #1;
        check("t6_clk_hs_req", 32'(clk_hs_req), 0);
        check("t6_dl_hs_req", 32'(dl_hs_req), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_in_ready", 32'(in_ready), 0);
        check("t6_dl_enable", 32'(dl_enable), 0);
        check("t6_dl_data", 32'(dl_data), 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge byte_clk);
        #1 byte_rst = 1'b0;
        base = enable_cnt;
        for (int i = 0; i < 3; i++) put_beat(beat_val(8'h80, i), i == 2, dc);
        drop_valid();
        wait_idle();
        check("t6_enable_cycles", 32'(enable_cnt - base), 3);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/dsi_hs_sequencer.md
# dsi_hs_sequencer

Sequences one high-speed burst of the DSI link. The block brings the clock lane into HS, then all data lanes, and streams packet beats into the data lanes. It then tears the lanes down in the reverse order. It sits between the packet builder (beat stream) and the clock-lane/data-lane PHY controllers, and owns their `hs_req` lines.

## Interface
- `LANES`, 2 — number of data lanes; 1, 2 or 4 supported.
- `T_CLK_PRE`, 8 — byte_clk cycles clock lane runs in HS before data lanes are requested (1..255).
- `T_CLK_POST`, 8 — byte_clk cycles clock lane stays in HS after all data lanes return idle (1..255).
- `TIMEOUT`, 1023 — max byte_clk cycles to wait for any rdy/idle condition (1..65535).

Ports:
- `byte_clk` in 1 — byte clock; all logic on rising edge.
- `byte_rst` in 1 — reset byte_rst, asynchronous, active-high; clock byte_clk.
- `in_data` in 8*LANES — packet beat; byte k goes to data lane k.
- `in_valid` in 1 — beat present.
- `in_last` in 1 — final beat of burst.
- `in_ready` out 1 — beat accepted this cycle when `in_valid` also high.
- `cont_clk` in 1 — 1: keep clock lane in HS between bursts.
- `clk_hs_req` out 1 — clock lane HS request.
- `clk_hs_rdy` in 1 — clock lane in HS.
- `clk_idle` in 1 — clock lane in LP11.
- `dl_hs_req` out 1 — HS request, shared by all data lanes.
- `dl_hs_rdy` in LANES — per-lane HS ready.
- `dl_idle` in LANES — per-lane LP11.
- `dl_data` out 8*LANES — data to lanes.
- `dl_enable` out 1 — data valid to all lanes.
- `busy` out 1 — state != IDLE.
- `underrun` out 1 — sticky: `in_valid` low inside a burst; cleared on next burst start.
- `timeout_err` out 1 — one-cycle pulse on wait timeout.

## Operation
- States: IDLE, CLK_START, CLK_PRE, DL_START, SEND, DL_STOP, CLK_POST, CLK_STOP, CLK_ON. CLK_ON means clock lane is in HS and no burst is in progress.
- IDLE: `in_valid` → CLK_START.
- CLK_START: `clk_hs_req`=1. `clk_hs_rdy` → CLK_PRE.
- CLK_PRE: count `T_CLK_PRE` cycles → DL_START.
- DL_START: `dl_hs_req`=1. Advance to SEND only when every bit of `dl_hs_rdy` is 1. Clear `underrun` on entry.
- SEND:
  - `in_ready`=1, `dl_enable`=`in_valid`, `dl_data`=`in_data`.
  - Accepted beat with `in_last` → DL_STOP.
  - Cycle with `in_valid`=0 sets `underrun`.
- DL_STOP: `dl_hs_req`=0. When all of `dl_idle` are 1: `cont_clk`=1 → CLK_ON, else → CLK_POST.
- CLK_POST: count `T_CLK_POST` cycles → CLK_STOP.
- CLK_STOP: `clk_hs_req`=0. `clk_idle` → IDLE.
- CLK_ON: `clk_hs_req`=1.
  - `in_valid` → DL_START.
  - else `cont_clk`=0 → CLK_POST.
  - `in_valid` has priority when both conditions hold.
- `clk_hs_req`=1 in CLK_START through CLK_POST and in CLK_ON. `dl_hs_req`=1 in DL_START and SEND only.
- Outside SEND: `in_ready`=0, `dl_enable`=0, `dl_data`=0.
- Timeout: one 16-bit counter serves the CLK_START, DL_START, DL_STOP and CLK_STOP waits. It is cleared on every state change.
- On reaching `TIMEOUT` the block pulses `timeout_err`, drops both requests and goes to IDLE. After a timeout the next burst starts normally.
- The CLK_PRE/CLK_POST counter is 8-bit, separate, and cleared on state entry.

## Timing
- Reset value of every output: 0; state IDLE. Reset mid-burst drops `clk_hs_req`/`dl_hs_req` asynchronously.
- All outputs are registered, except `in_ready`, `dl_enable` and `dl_data`, which decode the registered state combinationally.
- `in_valid` at cycle 0 in IDLE → `clk_hs_req`=1 from cycle 1.
- `clk_hs_rdy` seen at cycle n → CLK_PRE runs cycles n+1..n+T_CLK_PRE; `dl_hs_req`=1 from n+T_CLK_PRE+1.
- All `dl_hs_rdy` seen at cycle m → `in_ready`=1 from m+1.
- Last beat accepted at cycle k → `dl_hs_req`=0 at k+1.
- A beat is transferred only on cycles with `in_valid`&`in_ready`. `dl_enable` equals that condition exactly, one beat per cycle, no buffering.
- Waiting for a condition that is already true costs exactly one cycle in that state.

## Test plan
- Single burst, LANES=2, 3 beats (0x0201, 0x0403, 0x0605), rdy/idle return 2 cycles after request:
  - `dl_data` shows the beats in order with `dl_enable` high 3 cycles.
  - `dl_hs_req` rises exactly T_CLK_PRE+1 cycles after `clk_hs_rdy`.
  - `clk_hs_req` falls T_CLK_POST+1 cycles after all `dl_idle`.
- `dl_hs_rdy`=2'b01 held 20 cycles, then 2'b11 → `in_ready` stays 0 until the cycle after 2'b11.
- `in_valid` gap of 1 cycle mid-burst → `underrun`=1 until next DL_START; data order intact.
- `cont_clk`=1, two bursts 5 cycles apart:
  - `clk_hs_req` never falls.
  - Second burst enters DL_START directly from CLK_ON, with no CLK_START/CLK_PRE.
- `clk_hs_rdy` stuck 0, TIMEOUT=16 → `timeout_err` pulse 16 cycles after `clk_hs_req` rises; `clk_hs_req`=0 next cycle; `busy`=0.
- Assert `byte_rst` during SEND → all outputs 0 immediately; after release, a new burst completes normally.
